approx_error_monitor: RTL and testbench
=======================================

# approx_error_monitor

Downstream checker stage for the approximate adder tree. It consumes the tree's approximate sum and a reference (exact) sum for the same operand set, one pair per valid cycle. Over a window of N_SAMPLES accepted pairs it accumulates four metrics, then holds them until the next start: sum of absolute error, maximum absolute error, mismatch count and signed bias. It is used on the characterisation bench and on the FPGA error-measurement build.

## Interface
- W, 11, width of both sum inputs; matches the adder tree output.
- N_SAMPLES, 256, number of accepted pairs per measurement window; must be ≥ 1.
- ACC_W, 20, width of err_sum; err_bias is ACC_W+1 bits.
- CNT_W, $clog2(N_SAMPLES+1), width of the sample and mismatch counters.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse: clear metrics and open a window.
- in_valid  in  1  y_apx/y_ref valid this cycle.
- y_apx  in  W  approximate sum, unsigned.
- y_ref  in  W  exact sum, unsigned.
- busy  out  1  window open (RUN state).
- done  out  1  window complete; metrics stable.
- err_sum  out  ACC_W  Σ|y_apx − y_ref|, saturating.
- err_max  out  W  max |y_apx − y_ref|.
- err_cnt  out  CNT_W  number of pairs with y_apx ≠ y_ref.
- err_bias  out  ACC_W+1  signed Σ(y_apx − y_ref), saturating.
- sat  out  1  sticky; err_sum or err_bias has saturated this window.

## Operation
- **FSM states:** IDLE, RUN, DONE. The reset state is IDLE.
- **IDLE** –start→ RUN. **RUN** –Nth accepted pair→ DONE. **DONE** –start→ RUN.
- **start in any state:**
  - Clears all metrics, the sat flag, the sample counter and the stage-1 valid flag on the same edge.
  - Enters RUN.
  - in_valid is ignored on the start cycle.
- **Acceptance:** a pair is accepted on an edge where state = RUN, in_valid = 1, start = 0 and sample count < N_SAMPLES. After the Nth acceptance, further in_valid is ignored.
- **Stage 1 (registered):**
  - diff = {1'b0,y_apx} − {1'b0,y_ref`}, W+1 bits, two's complement.
  - abs = |diff|, W bits, range 0..2^W−1.
  - A mismatch flag and a valid flag are registered alongside.
- **Stage 2 (accumulate on stage-1 valid):**
  - err_sum += abs, clamped at 2^ACC_W−1.
  - err_bias += sign-extended diff, clamped at ±(2^ACC_W) limits, i.e. max 2^ACC_W−1, min −2^ACC_W.
  - err_max = max(err_max, abs).
  - err_cnt += mismatch.
  - sat is set if either clamp engages.
- **Transition to DONE:** the FSM enters DONE on the edge where the Nth pair's stage-2 update lands. done is 1 only in DONE; busy is 1 only in RUN.
- **Output holding:** metrics hold their value in IDLE and DONE, and are never modified outside stage-2 updates.
- **Abort:** a start while in RUN aborts the window. The in-flight stage-1 sample is discarded and is not accumulated.
- **Reset:** rst at any time, including mid-window, gives IDLE and all outputs 0 immediately.

## Timing
- **Reset values:** busy=0, done=0, err_sum=0, err_max=0, err_cnt=0, err_bias=0, sat=0.
- **start:** start sampled at edge s gives busy=1 after s and metrics=0 after s. The first pair can be accepted at edge s+1.
- **Latency:** a pair accepted at edge k is reflected in the metrics after edge k+1.
- **End of window:** the Nth pair accepted at edge k gives done=1 and busy=0 after edge k+1, with final metrics valid in that same cycle.
- **in_valid:** may be held low for any number of cycles inside RUN; gaps do not affect the result.
- **Back-to-back windows:** done held one cycle followed by start gives a new window with no dead cycle beyond the start cycle.
- **Throughput:** one pair per cycle.

## Test plan
All scenarios except the first use N_SAMPLES=4.
- **Reset:** rst pulse, then idle 5 cycles. Required: every output 0, busy=0, done=0.
- **Exact match:**
  - Stimulus: start, then 4 consecutive pairs apx=ref=100.
  - Required: done 1 cycle after the 4th pair; err_sum=0, err_max=0, err_cnt=0, err_bias=0, sat=0.
- **Mixed error:**
  - Stimulus: pairs (7,10), (7,10), (15,10), (9,9) with in_valid gaps of 0, 2 and 1 cycles.
  - Required: err_sum=11, err_max=5, err_cnt=3, err_bias=−1; done 1 cycle after the last pair.
- **Abort:**
  - Stimulus: start, pairs (0,5) and (0,5), then start again and pairs (3,1) ×4. The second start must be issued while (0,5) is still in stage 1.
  - Required: err_sum=8, err_max=2, err_cnt=4, err_bias=+8.
- **Saturation:**
  - Stimulus: ACC_W=12; pairs (2047,0) ×4.
  - Required: err_sum=4095, sat=1, err_max=2047, err_bias=4095; a following start clears sat to 0.
- **Reset mid-window and excess input:**
  - Stimulus: rst asserted after 2 pairs, then a clean run with 6 pairs (1,0).
  - Required: after rst, all outputs are 0 immediately. In the clean run only 4 pairs are counted, giving err_cnt=4 and err_sum=4, and done stays 1 with no further change.

Source files
------------

// File: rtl/approx_error_monitor.sv
// approx_error_monitor
// Checker stage that sits after the approximate adder tree. For each
// measurement window of N_SAMPLES accepted (approximate, exact) sum pairs it
// accumulates four metrics: saturating sum of absolute error, maximum absolute
// error, mismatch count and saturating signed bias. The metrics are then held
// until the next start. The datapath has two stages: stage 1 registers the
// difference, and stage 2 accumulates it.
module approx_error_monitor #(
  parameter int W         = 11,
  parameter int N_SAMPLES = 256,
  parameter int ACC_W     = 20,
  parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [W-1:0]     y_apx,
  input  logic [W-1:0]     y_ref,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] err_sum,
  output logic [W-1:0]     err_max,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W:0]   err_bias,
  output logic             sat
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  // Sample counter and stage-1 pipeline registers
  logic [CNT_W-1:0] cnt_q;
  logic             s1_valid_q, s1_mis_q, s1_last_q;
  logic [W:0]       s1_diff_q;
  logic [W-1:0]     s1_abs_q;

  // Metric registers
  logic [ACC_W-1:0] err_sum_q;
  logic [W-1:0]     err_max_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [ACC_W:0]   err_bias_q;
  logic             sat_q;

  // Control and datapath nets
  logic             accept, last_pair, upd;
  logic [W:0]       diff_d, diff_neg;
  logic [W-1:0]     abs_d;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W+1:0] bias_ext;
  logic             sum_ovf, bias_ovf;
  logic [ACC_W-1:0] sum_d;
  logic [ACC_W:0]   bias_d;

  // A pair is taken only inside an open window that still has room. A start
  // on the same edge takes priority over acceptance.
  assign accept    = (state_q == S_RUN) && in_valid && !start &&
                     (cnt_q < CNT_W'(N_SAMPLES));
  assign last_pair = (cnt_q == CNT_W'(N_SAMPLES - 1));
  // A start discards the in-flight stage-1 sample instead of accumulating it.
  assign upd       = s1_valid_q && !start;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples pre-edge values regardless of the order of the always blocks.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic: start always (re)opens a window, and the window
  // closes when the last pair's stage-2 update lands.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches on
    // every path through the case statement.
    state_d = state_q;
    if (start) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN:   if (upd && s1_last_q) state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // Stage-1 difference: a (W+1)-bit two's-complement value, and its magnitude.
  // The magnitude always fits in W bits.
  always_comb begin
    diff_d   = {1'b0, y_apx} - {1'b0, y_ref};
    diff_neg = -diff_d;
    abs_d    = diff_d[W] ? diff_neg[W-1:0] : diff_d[W-1:0];
  end

  // Sample counter: cleared by start, advanced on each accepted pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt_q <= '0;
    else if (start)  cnt_q <= '0;
    else if (accept) cnt_q <= cnt_q + CNT_W'(1);
  end

  // Stage-1 registers. The valid flag qualifies the data, so the data fields
  // only load on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_diff_q  <= '0;
      s1_abs_q   <= '0;
      s1_mis_q   <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_diff_q <= diff_d;
        s1_abs_q  <= abs_d;
        s1_mis_q  <= (y_apx != y_ref);
        s1_last_q <= last_pair;
      end
    end
  end

  // Stage-2 saturating arithmetic. The sum is widened by one bit to catch
  // carry-out. The bias is widened by one bit, and it overflowed when the
  // two top bits disagree.
  always_comb begin
    sum_ext  = {1'b0, err_sum_q} + {{(ACC_W + 1 - W){1'b0}}, s1_abs_q};
    sum_ovf  = sum_ext[ACC_W];
    sum_d    = sum_ovf ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
    bias_ext = {err_bias_q[ACC_W], err_bias_q} +
               {{(ACC_W + 1 - W){s1_diff_q[W]}}, s1_diff_q};
    bias_ovf = bias_ext[ACC_W+1] ^ bias_ext[ACC_W];
    if (!bias_ovf)              bias_d = bias_ext[ACC_W:0];
    else if (bias_ext[ACC_W+1]) bias_d = {1'b1, {ACC_W{1'b0}}};
    else                        bias_d = {1'b0, {ACC_W{1'b1}}};
  end

  // Stage-2 metric registers: cleared by start, and updated only by a valid
  // stage-1 sample. Otherwise they hold in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || start) begin
      err_sum_q  <= '0;
      err_max_q  <= '0;
      err_cnt_q  <= '0;
      err_bias_q <= '0;
      sat_q      <= 1'b0;
    end else if (upd) begin
      err_sum_q  <= sum_d;
      err_bias_q <= bias_d;
      if (s1_abs_q > err_max_q) err_max_q <= s1_abs_q;
      err_cnt_q  <= err_cnt_q + CNT_W'(s1_mis_q);
      sat_q      <= sat_q | sum_ovf | bias_ovf;
    end
  end

  assign err_sum  = err_sum_q;
  assign err_max  = err_max_q;
  assign err_cnt  = err_cnt_q;
  assign err_bias = err_bias_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Self-checking bench for approx_error_monitor. It drives three instances
// from one shared stimulus:
//   - the default parameters;
//   - N_SAMPLES=4 with ACC_W=20;
//   - N_SAMPLES=4 with ACC_W=12, so that saturation is reachable.
// The bench uses table vectors, hand-written corner sequences, and random
// windows checked against an arithmetic reference model.
module tb_approx_error_monitor;

  localparam int W = 11;

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic [W-1:0] y_apx, y_rf;

  // N_SAMPLES=4, ACC_W=20
  logic d_busy, d_done, d_sat;
  logic [19:0] d_sum;
  logic [W-1:0] d_max;
  logic [2:0] d_cnt;
  logic [20:0] d_bias;
  // N_SAMPLES=4, ACC_W=12
  logic s_busy, s_done, s_sat;
  logic [11:0] s_sum;
  logic [W-1:0] s_max;
  logic [2:0] s_cnt;
  logic [12:0] s_bias;
  // default parameters
  logic f_busy, f_done, f_sat;
  logic [19:0] f_sum;
  logic [W-1:0] f_max;
  logic [8:0] f_cnt;
  logic [20:0] f_bias;

  always #5 clk = ~clk;

  approx_error_monitor #(.W(W), .N_SAMPLES(4), .ACC_W(20)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .y_apx(y_apx), .y_ref(y_rf), .busy(d_busy), .done(d_done),
    .err_sum(d_sum), .err_max(d_max), .err_cnt(d_cnt), .err_bias(d_bias),
    .sat(d_sat));

  approx_error_monitor #(.W(W), .N_SAMPLES(4), .ACC_W(12)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .y_apx(y_apx), .y_ref(y_rf), .busy(s_busy), .done(s_done),
    .err_sum(s_sum), .err_max(s_max), .err_cnt(s_cnt), .err_bias(s_bias),
    .sat(s_sat));

  approx_error_monitor dut_def (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .y_apx(y_apx), .y_ref(y_rf), .busy(f_busy), .done(f_done),
    .err_sum(f_sum), .err_max(f_max), .err_cnt(f_cnt), .err_bias(f_bias),
    .sat(f_sat));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, let the rising edge take them, and then
  // settle 1 ns past that edge.
  task automatic step(input logic s, input logic v, input int a, input int r);
    start = s; in_valid = v; y_apx = W'(a); y_rf = W'(r);
    @(posedge clk);
    #1;
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
  endtask

  task automatic check_d(input string tag, input int e_sum, input int e_max,
                         input int e_cnt, input int e_bias);
    check({tag, "_sum"},  d_sum, e_sum);
    check({tag, "_max"},  d_max, e_max);
    check({tag, "_cnt"},  d_cnt, e_cnt);
    check({tag, "_bias"}, $signed(d_bias), e_bias);
  endtask

  // Reference model: fold the first four accepted pairs with running clamps.
  typedef struct {
    longint sum, mx, cnt, bias;
    logic   sat;
  } exp_t;

  function automatic exp_t model(input int ap[4], input int rv[4], input int acc_w);
    exp_t   e;
    longint smax, bmax, bmin, d, a;
    e = '{0, 0, 0, 0, 1'b0};
    smax = (longint'(1) << acc_w) - 1;
    bmax = smax;
    bmin = -(longint'(1) << acc_w);
    for (int i = 0; i < 4; i++) begin
      d = longint'(ap[i]) - longint'(rv[i]);
      a = (d < 0) ? -d : d;
      e.sum += a;
      if (e.sum > smax) begin e.sum = smax; e.sat = 1'b1; end
      e.bias += d;
      if (e.bias > bmax) begin e.bias = bmax; e.sat = 1'b1; end
      if (e.bias < bmin) begin e.bias = bmin; e.sat = 1'b1; end
      if (a > e.mx) e.mx = a;
      if (d != 0) e.cnt++;
    end
    return e;
  endfunction

  // Table vectors: four pairs, idle cycles after each pair, expected metrics
  typedef struct {
    int ap[4];
    int rv[4];
    int gap[4];
    int e_sum, e_max, e_cnt, e_bias;
  } vec_t;

  vec_t vecs[4];

  initial begin
    exp_t e;
    int   ap[4], rv[4];
    int   nv, t;

    // Exact match
    vecs[0].ap = '{100, 100, 100, 100}; vecs[0].rv = '{100, 100, 100, 100};
    vecs[0].gap = '{0, 0, 0, 0};
    vecs[0].e_sum = 0; vecs[0].e_max = 0; vecs[0].e_cnt = 0; vecs[0].e_bias = 0;
    // Mixed error with gaps of 0, 2 and 1 cycles
    vecs[1].ap = '{7, 7, 15, 9};        vecs[1].rv = '{10, 10, 10, 9};
    vecs[1].gap = '{0, 2, 1, 0};
    vecs[1].e_sum = 11; vecs[1].e_max = 5; vecs[1].e_cnt = 3; vecs[1].e_bias = -1;
    // Full-scale differences in both directions
    vecs[2].ap = '{0, 2047, 5, 1};      vecs[2].rv = '{2047, 0, 5, 0};
    vecs[2].gap = '{1, 0, 3, 0};
    vecs[2].e_sum = 4095; vecs[2].e_max = 2047; vecs[2].e_cnt = 3; vecs[2].e_bias = 1;
    // Cancelling bias
    vecs[3].ap = '{500, 100, 300, 0};   vecs[3].rv = '{100, 500, 299, 1};
    vecs[3].gap = '{0, 0, 0, 0};
    vecs[3].e_sum = 802; vecs[3].e_max = 400; vecs[3].e_cnt = 4; vecs[3].e_bias = 0;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; y_apx = '0; y_rf = '0;

    // Reset: pulse rst, stay idle for 5 cycles, and expect every output at 0.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(5);
    check("rst_busy", d_busy, 0);
    check("rst_done", d_done, 0);
    check_d("rst", 0, 0, 0, 0);
    check("rst_sat", d_sat, 0);
    check("rst_s_busy", s_busy, 0);
    check("rst_s_sum", s_sum, 0);
    check("rst_f_busy", f_busy, 0);
    check("rst_f_done", f_done, 0);
    check("rst_f_sum", f_sum, 0);
    check("rst_f_cnt", f_cnt, 0);
    check("rst_f_bias", f_bias, 0);
    check("rst_f_sat", f_sat, 0);

    // Table vectors, run back to back (start comes right after the done cycle)
    for (int v = 0; v < 4; v++) begin
      step(1'b1, 1'b0, 0, 0);
      check($sformatf("vec%0d_start_busy", v), d_busy, 1);
      check_d($sformatf("vec%0d_clear", v), 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
        step(1'b0, 1'b1, vecs[v].ap[i], vecs[v].rv[i]);
        if (i < 3) idle(vecs[v].gap[i]);
      end
      check($sformatf("vec%0d_done_early", v), d_done, 0);
      idle(1);
      check($sformatf("vec%0d_done", v), d_done, 1);
      check($sformatf("vec%0d_busy", v), d_busy, 0);
      check_d($sformatf("vec%0d", v), vecs[v].e_sum, vecs[v].e_max,
              vecs[v].e_cnt, vecs[v].e_bias);
      check($sformatf("vec%0d_sat", v), d_sat, 0);
    end

    // Abort: the second start arrives while the second (0,5) is in stage 1.
    step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b1, 0, 5);
    step(1'b0, 1'b1, 0, 5);
    check("abort_partial_sum", d_sum, 5);
    step(1'b1, 1'b0, 0, 0);
    check("abort_cleared", d_sum, 0);
    idle(1);
    check("abort_discarded", d_sum, 0);
    check("abort_busy", d_busy, 1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3, 1);
    idle(1);
    check("abort_done", d_done, 1);
    check_d("abort", 8, 2, 4, 8);

    // Saturation on the ACC_W=12 instance
    step(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2047, 0);
    idle(1);
    check("sat_done", s_done, 1);
    check("sat_sum", s_sum, 4095);
    check("sat_flag", s_sat, 1);
    check("sat_max", s_max, 2047);
    check("sat_bias", $signed(s_bias), 4095);
    check("sat_wide_sum", d_sum, 8188);
    check("sat_wide_flag", d_sat, 0);
    step(1'b1, 1'b0, 0, 0);
    check("sat_cleared", s_sat, 0);

    // Reset in mid-window, then a clean run with excess input
    step(0, 1'b1, 1, 0);
    step(0, 1'b1, 1, 0);
    check("midrst_pre_sum", d_sum, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", d_busy, 0);
    check("midrst_done", d_done, 0);
    check_d("midrst", 0, 0, 0, 0);
    check("midrst_sat", d_sat, 0);
    check("midrst_f_busy", f_busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1, 0);
    check("excess_done", d_done, 1);
    check_d("excess", 4, 1, 4, 4);
    idle(3);
    check("excess_hold_done", d_done, 1);
    check_d("excess_hold", 4, 1, 4, 4);

    // Random windows checked against the model on both N=4 instances
    for (int w = 0; w < 20; w++) begin
      step(1'b1, 1'b0, 0, 0);
      nv = $urandom_range(4, 6);
      for (int i = 0; i < nv; i++) begin
        int a, r;
        a = $urandom_range(0, 2047);
        r = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 2047);
        if (i < 4) begin ap[i] = a; rv[i] = r; end
        step(1'b0, 1'b1, a, r);
        idle($urandom_range(0, 2));
      end
      t = 0;
      while (!d_done && t < 8) begin idle(1); t++; end
      check($sformatf("rand%0d_done", w), d_done, 1);
      e = model(ap, rv, 20);
      check_d($sformatf("rand%0d", w), int'(e.sum), int'(e.mx), int'(e.cnt),
              int'(e.bias));
      check($sformatf("rand%0d_sat", w), d_sat, e.sat);
      e = model(ap, rv, 12);
      check($sformatf("rand%0d_s_sum", w), s_sum, e.sum);
      check($sformatf("rand%0d_s_bias", w), $signed(s_bias), e.bias);
      check($sformatf("rand%0d_s_sat", w), s_sat, e.sat);
      check($sformatf("rand%0d_s_max", w), s_max, e.mx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
